// File: rtl/branch_update_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : branch_update_queue_if
// Brief    : Execute-side push and predictor-update-side signals of the queue.
// Revision : 1.0 - initial release
// ============================================================================
interface branch_update_queue_if #(
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 32
);
    localparam int c_CNT_W = $clog2(DEPTH) + 1;

    logic                  ex_valid_i;
    logic                  ex_taken_i;
    logic [ADDR_WIDTH-1:0] ex_pc_i;
    logic [ADDR_WIDTH-1:0] ex_target_i;
    logic                  ex_ready_o;
    logic                  hold_i;
    logic                  flush_i;
    logic                  branch_valid_o;
    logic                  branch_taken_o;
    logic [ADDR_WIDTH-1:0] branch_pc_o;
    logic [ADDR_WIDTH-1:0] branch_target_o;
    logic [c_CNT_W-1:0]    count_o;
    logic [31:0]           drop_count_o;

    modport master (
        output ex_valid_i, ex_taken_i, ex_pc_i, ex_target_i, hold_i, flush_i,
        input  ex_ready_o, branch_valid_o, branch_taken_o, branch_pc_o,
               branch_target_o, count_o, drop_count_o
    );

    modport slave (
        input  ex_valid_i, ex_taken_i, ex_pc_i, ex_target_i, hold_i, flush_i,
        output ex_ready_o, branch_valid_o, branch_taken_o, branch_pc_o,
               branch_target_o, count_o, drop_count_o
    );
endinterface
`default_nettype wire

// File: rtl/branch_update_queue.sv
`default_nettype none
// ============================================================================
// Module   : branch_update_queue
// Brief    : In-order FIFO replaying resolved branches onto the predictor update port.
// Revision : 1.0 - initial release
// ============================================================================
module branch_update_queue #(
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 32
) (
    input  wire logic             clk,
    input  wire logic             rst,
    branch_update_queue_if.slave  bus
);
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

    logic                  r_mem_taken  [DEPTH];
    logic [ADDR_WIDTH-1:0] r_mem_pc     [DEPTH];
    logic [ADDR_WIDTH-1:0] r_mem_target [DEPTH];

    logic [c_PTR_W-1:0]    r_head;
    logic [c_PTR_W-1:0]    r_tail;
    logic [c_CNT_W-1:0]    r_count;
    logic [31:0]           r_drops;
    logic                  r_valid;
    logic                  r_taken;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] r_target;

    logic w_ready;
    logic w_push;
    logic w_drop;
    logic w_pop;

    // Ready comes from registered occupancy only, so a full queue drops even when popping.
    always_comb begin
        w_ready = (r_count != c_FULL);
        w_push  = bus.ex_valid_i &&  w_ready && !bus.flush_i;
        w_drop  = bus.ex_valid_i && !w_ready && !bus.flush_i;
        w_pop   = (r_count != '0) && !bus.hold_i && !bus.flush_i;
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_taken[r_tail]  <= bus.ex_taken_i;
            r_mem_pc[r_tail]     <= bus.ex_pc_i;
            r_mem_target[r_tail] <= bus.ex_target_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
            r_drops  <= '0;
            r_valid  <= 1'b0;
            r_taken  <= 1'b0;
            r_pc     <= '0;
            r_target <= '0;
        end else begin
            r_valid <= w_pop;
            if (w_drop && (r_drops != 32'hFFFF_FFFF)) begin
                r_drops <= r_drops + 32'd1;
            end
            if (bus.flush_i) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) begin
                    r_tail <= r_tail + 1'b1;
                end
                if (w_pop) begin
                    r_head   <= r_head + 1'b1;
                    r_taken  <= r_mem_taken[r_head];
                    r_pc     <= r_mem_pc[r_head];
                    r_target <= r_mem_target[r_head];
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    assign bus.ex_ready_o      = w_ready;
    assign bus.branch_valid_o  = r_valid;
    assign bus.branch_taken_o  = r_taken;
    assign bus.branch_pc_o     = r_pc;
    assign bus.branch_target_o = r_target;
    assign bus.count_o         = r_count;
    assign bus.drop_count_o    = r_drops;
endmodule
`default_nettype wire
